unidade_controle_rodadas: RTL and testbench

- Parametrised control unit for the memory-sequence game.
- Play is round-based: in round r the player must repeat memory positions 0..r.
- Each completed round extends the sequence by one position. The game is won after N_RODADAS rounds.
- Block owns the address counter, round counter, life counter and an optional per-move timeout timer. It sits between the edge-detected button logic and the datapath (jogada register, sequence memory, comparator).

---
 rtl/jogo_pkg.sv | 36 +++
 rtl/contador_timeout.sv | 32 +++
 rtl/unidade_controle_rodadas.sv | 126 ++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared state encodings and helpers for the memory-sequence game controller.
// State codes double as the display codes shown on db_estado.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    INICIA_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    TIMEOUT       = 4'h7,
    FIM_RODADA    = 4'h8,
    ERRO_PARCIAL  = 4'h9,
    ACERTOU       = 4'hA,
    ERROU         = 4'hE
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  function automatic int largura_vidas(input int vidas);
    return (vidas < 1) ? 1 : $clog2(vidas + 1);
  endfunction

  function automatic logic [3:0] codigo_display(input logic [3:0] estado);
    case (estado)
      INICIAL, PREPARACAO, INICIA_RODADA, ESPERA, REGISTRA, COMPARACAO,
      PROXIMO, TIMEOUT, FIM_RODADA, ERRO_PARCIAL, ACERTOU, ERROU:
        return estado;
      default:
        return DB_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-move timer: counts espera cycles and flags the last allowed one.
// Saturates at its terminal value so it can never wrap back to zero.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] r_timer;
  logic          w_fim;

  assign w_fim = (r_timer == ULTIMO);
  assign fim   = w_fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (zera) begin
      r_timer <= '0;
    end else if (conta && !w_fim) begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round/address/life sequencing for the memory game; all outputs are Moore
// decodes of the registered state and counters.
module unidade_controle_rodadas
  import jogo_pkg::*;
#(
  parameter  int ADDR_W         = 4,
  parameter  int N_RODADAS      = 16,
  parameter  int TIMEOUT_CICLOS = 5000,
  parameter  int VIDAS          = 1,
  localparam int VW             = largura_vidas(VIDAS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic              modo_timeout,
  output logic              zeraR,
  output logic              registraR,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic [VW-1:0]     vidas,
  output logic              acertou,
  output logic              errou,
  output logic              timeout_out,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam logic [ADDR_W-1:0] RODADA_MAX = ADDR_W'(N_RODADAS - 1);
  localparam logic [VW-1:0]     VIDAS_INI  = VW'(VIDAS);

  estado_t           r_estado;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_rodada;
  logic [VW-1:0]     r_vidas;
  logic              r_modo;

  logic w_zera_timer;
  logic w_conta_timer;
  logic w_fim_timer;

  assign w_zera_timer  = (r_estado == INICIA_RODADA) || (r_estado == PROXIMO);
  assign w_conta_timer = (r_estado == ESPERA) && r_modo;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock(clock),
    .reset(reset),
    .zera (w_zera_timer),
    .conta(w_conta_timer),
    .fim  (w_fim_timer)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_endereco <= '0;
      r_rodada   <= '0;
      r_vidas    <= VIDAS_INI;
      r_modo     <= 1'b0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) r_estado <= PREPARACAO;
        end
        PREPARACAO: begin
          r_rodada <= '0;
          r_vidas  <= VIDAS_INI;
          r_modo   <= modo_timeout;
          r_estado <= INICIA_RODADA;
        end
        INICIA_RODADA: begin
          r_endereco <= '0;
          r_estado   <= ESPERA;
        end
        // A move arriving on the timer's last cycle still counts.
        ESPERA: begin
          if (jogada) r_estado <= REGISTRA;
          else if (r_modo && w_fim_timer) r_estado <= TIMEOUT;
        end
        REGISTRA: begin
          r_estado <= COMPARACAO;
        end
        COMPARACAO: begin
          if (!igual && (r_vidas == VW'(1))) r_estado <= ERROU;
          else if (!igual) r_estado <= ERRO_PARCIAL;
          else if ((r_endereco == r_rodada) && (r_rodada == RODADA_MAX)) r_estado <= ACERTOU;
          else if (r_endereco == r_rodada) r_estado <= FIM_RODADA;
          else r_estado <= PROXIMO;
        end
        PROXIMO: begin
          r_endereco <= r_endereco + ADDR_W'(1);
          r_estado   <= ESPERA;
        end
        FIM_RODADA: begin
          r_rodada <= r_rodada + ADDR_W'(1);
          r_estado <= INICIA_RODADA;
        end
        ERRO_PARCIAL: begin
          r_vidas  <= r_vidas - VW'(1);
          r_estado <= INICIA_RODADA;
        end
        TIMEOUT, ERROU, ACERTOU: begin
          if (iniciar) r_estado <= PREPARACAO;
        end
        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  assign zeraR       = (r_estado == INICIAL) || (r_estado == PREPARACAO);
  assign registraR   = (r_estado == REGISTRA);
  assign acertou     = (r_estado == ACERTOU);
  assign errou       = (r_estado == ERROU);
  assign timeout_out = (r_estado == TIMEOUT);
  assign pronto      = acertou || errou || timeout_out;
  assign endereco    = r_endereco;
  assign rodada      = r_rodada;
  assign vidas       = r_vidas;
  assign db_estado   = codigo_display(r_estado);

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Scoreboard bench: stimulus plays games against a move-level game model,
// a monitor checks each registered move and each game ending.
module tb_unidade_controle_rodadas;

  localparam int ADDR_W = 2;
  localparam int N_ROD  = 4;
  localparam int TOUT   = 8;
  localparam int VID    = 2;
  localparam int VW     = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic jogada = 1'b0;
  logic igual = 1'b0;
  logic modo_timeout = 1'b0;

  logic              zeraR, registraR, acertou, errou, timeout_out, pronto;
  logic [ADDR_W-1:0] endereco, rodada;
  logic [VW-1:0]     vidas;
  logic [3:0]        db_estado;

  unidade_controle_rodadas #(
    .ADDR_W(ADDR_W), .N_RODADAS(N_ROD), .TIMEOUT_CICLOS(TOUT), .VIDAS(VID)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .modo_timeout(modo_timeout), .zeraR(zeraR),
    .registraR(registraR), .endereco(endereco), .rodada(rodada),
    .vidas(vidas), .acertou(acertou), .errou(errou),
    .timeout_out(timeout_out), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { int rod; int ende; int vid; } mov_t;
  typedef struct { int ac; int er; int to; int db; int rod; int ende; int vid; } fim_t;

  mov_t q_mov[$];
  fim_t q_fim[$];
  int n_vec = 0;
  int n_err = 0;

  // game model state, one step per move
  int m_rod, m_end, m_vid;
  bit m_fim;

  task automatic check(input string nome, input int atual, input int esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  // monitor
  logic pronto_ant = 1'b0;
  always @(negedge clock) begin
    mov_t e;
    fim_t f;
    if (reset) begin
      pronto_ant = 1'b0;
    end else begin
      if (registraR) begin
        if (q_mov.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL registraR_unexpected: got registraR=1 expected no move");
        end else begin
          e = q_mov.pop_front();
          check("mov_endereco", int'(endereco), e.ende);
          check("mov_rodada", int'(rodada), e.rod);
          check("mov_vidas", int'(vidas), e.vid);
        end
      end
      if (pronto && !pronto_ant) begin
        if (q_fim.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pronto_unexpected: got pronto=1 db=%0d expected game running", db_estado);
        end else begin
          f = q_fim.pop_front();
          check("fim_acertou", int'(acertou), f.ac);
          check("fim_errou", int'(errou), f.er);
          check("fim_timeout", int'(timeout_out), f.to);
          check("fim_db_estado", int'(db_estado), f.db);
          check("fim_rodada", int'(rodada), f.rod);
          check("fim_endereco", int'(endereco), f.ende);
          check("fim_vidas", int'(vidas), f.vid);
        end
      end
      pronto_ant = pronto;
    end
  end

  task automatic espera_estado(input int code, input int max, input string nome);
    int k = 0;
    while (db_estado !== 4'(code) && k < max) begin
      @(negedge clock);
      k++;
    end
    if (db_estado !== 4'(code)) begin
      n_vec++; n_err++;
      $display("FAIL %s: got state %0d expected state %0d within %0d cycles", nome, db_estado, code, max);
    end
  endtask

  task automatic espera_pronto(input int max);
    int k = 0;
    while (pronto !== 1'b1 && k < max) begin
      @(negedge clock);
      k++;
    end
    if (pronto !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_pronto: got pronto=%0b expected 1 within %0d cycles", pronto, max);
    end
  endtask

  task automatic inicio_jogo(input bit modo);
    modo_timeout = modo;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("start_preparacao", int'(db_estado), 1);
    check("start_zeraR", int'(zeraR), 1);
    @(negedge clock);
    check("start_db", int'(db_estado), 2);
    check("start_rodada", int'(rodada), 0);
    check("start_vidas", int'(vidas), VID);
    modo_timeout = $urandom_range(0, 1);
    m_rod = 0; m_end = 0; m_vid = VID; m_fim = 1'b0;
  endtask

  task automatic faz_jogada(input bit ig, input int atraso);
    espera_estado(3, 60, "wait_espera");
    repeat (atraso) @(negedge clock);
    q_mov.push_back('{rod: m_rod, ende: m_end, vid: m_vid});
    jogada = 1'b1;
    igual = ig;
    iniciar = ($urandom_range(0, 3) == 0);
    @(negedge clock);
    iniciar = 1'b0;
    jogada = ($urandom_range(0, 2) == 0);
    @(negedge clock);
    jogada = 1'b0;
    if (!ig) begin
      if (m_vid == 1) begin
        q_fim.push_back('{ac: 0, er: 1, to: 0, db: 14, rod: m_rod, ende: m_end, vid: m_vid});
        m_fim = 1'b1;
      end else begin
        m_vid--;
        m_end = 0;
      end
    end else if (m_end == m_rod) begin
      if (m_rod == N_ROD - 1) begin
        q_fim.push_back('{ac: 1, er: 0, to: 0, db: 10, rod: m_rod, ende: m_end, vid: m_vid});
        m_fim = 1'b1;
      end else begin
        m_rod++;
        m_end = 0;
      end
    end else begin
      m_end++;
    end
  endtask

  task automatic faz_timeout();
    int k = 0;
    espera_estado(3, 60, "wait_espera_to");
    q_fim.push_back('{ac: 0, er: 0, to: 1, db: 7, rod: m_rod, ende: m_end, vid: m_vid});
    while (db_estado === 4'd3 && k < 3 * TOUT) begin
      @(negedge clock);
      k++;
    end
    check("timeout_espera_cycles", k, TOUT);
    m_fim = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit modo;
    int nao_espera;

    @(negedge clock);
    check("rst_db", int'(db_estado), 0);
    check("rst_endereco", int'(endereco), 0);
    check("rst_rodada", int'(rodada), 0);
    check("rst_vidas", int'(vidas), VID);
    check("rst_zeraR", int'(zeraR), 1);
    check("rst_registraR", int'(registraR), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_flags", int'({acertou, errou, timeout_out}), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_inicial", int'(db_estado), 0);

    // perfect game, then restart from acertou
    inicio_jogo(1'b0);
    while (!m_fim) faz_jogada(1'b1, $urandom_range(0, 3));
    espera_pronto(20);
    check("perfect_db", int'(db_estado), 10);

    // partial error in round 1, then final error
    inicio_jogo(1'b0);
    faz_jogada(1'b1, 0);
    faz_jogada(1'b1, 1);
    faz_jogada(1'b0, 0);
    espera_estado(3, 20, "wait_replay");
    check("replay_endereco", int'(endereco), 0);
    check("replay_rodada", int'(rodada), 1);
    check("replay_vidas", int'(vidas), 1);
    faz_jogada(1'b1, 0);
    faz_jogada(1'b1, 2);
    faz_jogada(1'b1, 0);
    faz_jogada(1'b0, 0);
    espera_pronto(20);
    repeat (3) @(negedge clock);
    check("errou_vidas_held", int'(vidas), 1);
    check("errou_db_held", int'(db_estado), 14);

    // timer tie on the last cycle, then timeout
    inicio_jogo(1'b1);
    faz_jogada(1'b1, 2);
    faz_jogada(1'b1, TOUT - 1);
    faz_timeout();
    espera_pronto(20);

    // no timer: long idle stays in espera
    inicio_jogo(1'b0);
    espera_estado(3, 20, "wait_idle");
    nao_espera = 0;
    repeat (100) begin
      @(negedge clock);
      if (db_estado !== 4'd3) nao_espera++;
    end
    check("idle_no_timeout", nao_espera, 0);
    faz_jogada(1'b1, 0);
    faz_jogada(1'b1, 0);

    // async reset while in comparacao
    espera_estado(3, 20, "wait_pre_reset");
    q_mov.push_back('{rod: m_rod, ende: m_end, vid: m_vid});
    jogada = 1'b1; igual = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
    check("pre_reset_comparacao", int'(db_estado), 5);
    check("pre_reset_endereco", int'(endereco), 1);
    reset = 1'b1;
    #1;
    check("async_rst_db", int'(db_estado), 0);
    check("async_rst_endereco", int'(endereco), 0);
    check("async_rst_rodada", int'(rodada), 0);
    check("async_rst_vidas", int'(vidas), VID);
    check("async_rst_zeraR", int'(zeraR), 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // randomized games
    for (int g = 0; g < 8; g++) begin
      modo = $urandom_range(0, 1);
      inicio_jogo(modo);
      while (!m_fim) begin
        if (modo && $urandom_range(0, 14) == 0) faz_timeout();
        else faz_jogada($urandom_range(0, 4) != 0, $urandom_range(0, 3));
      end
      espera_pronto(20 + 2 * TOUT);
      @(negedge clock);
    end

    repeat (4) @(negedge clock);
    check("pending_moves", q_mov.size(), 0);
    check("pending_endings", q_fim.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
